// File: rtl/pe_job_scheduler.sv
// ---------------------------------------------------------------------------
// pe_job_scheduler
//
// Job-level sequencer for the 4-lane PE datapath. Takes vector job
// descriptors over a valid/ready handshake and expands each one into a
// stream of per-beat opcodes with operand/destination addresses for the
// PE fetch unit. It appends pipeline drain bubbles after the last beat,
// appends a STORE_RESULT for dot products, and parks in a halted state on
// STOP until reset.
//
// Ports
//   clk            rising-edge clock
//   rstn           asynchronous, active-low reset
//   job_valid      descriptor valid
//   job_ready      scheduler can accept a descriptor (IDLE only)
//   job_op         ADD=1, SUB=2, MUL=3, DOTP=4, STOP=8
//   job_a_addr     operand A base beat address
//   job_b_addr     operand B base beat address
//   job_dst_addr   destination base beat address
//   job_len        job length in beats
//   issue_stall    fetch path cannot take a beat this cycle
//   issue_opcode   opcode to the PEs (NOOP=0 when nothing is issued)
//   issue_a_addr   per-beat operand A address
//   issue_b_addr   per-beat operand B address
//   issue_dst_addr per-beat destination address
//   busy           job in progress
//   done           one-cycle job-complete pulse
//   err            one-cycle illegal-descriptor pulse
//   halted         STOP has been executed
//
// Every output is a register. The issue-side STORE_RESULT opcode is
// encoded as 5, a value that is never a legal job opcode, so the PEs can
// tell it apart from anything a host can submit.
// ---------------------------------------------------------------------------
module pe_job_scheduler #(
  parameter int OPCODE_WIDTH = 4,
  parameter int ADDR_WIDTH   = 10,
  parameter int LEN_WIDTH    = 8,
  parameter int PIPE_LAT     = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    job_valid,
  output logic                    job_ready,
  input  logic [OPCODE_WIDTH-1:0] job_op,
  input  logic [ADDR_WIDTH-1:0]   job_a_addr,
  input  logic [ADDR_WIDTH-1:0]   job_b_addr,
  input  logic [ADDR_WIDTH-1:0]   job_dst_addr,
  input  logic [LEN_WIDTH-1:0]    job_len,
  input  logic                    issue_stall,
  output logic [OPCODE_WIDTH-1:0] issue_opcode,
  output logic [ADDR_WIDTH-1:0]   issue_a_addr,
  output logic [ADDR_WIDTH-1:0]   issue_b_addr,
  output logic [ADDR_WIDTH-1:0]   issue_dst_addr,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    halted
);

  localparam logic [OPCODE_WIDTH-1:0] OP_NOOP  = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD   = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB   = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_MUL   = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_DOTP  = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_STORE = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_STOP  = OPCODE_WIDTH'(8);

  // Drain counter runs 0..PIPE_LAT, so it needs room for PIPE_LAT itself.
  localparam int DW = $clog2(PIPE_LAT + 1);
  localparam logic [DW-1:0] DRAIN_ONE  = DW'(1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LAT - 1);
  localparam logic [DW-1:0] DRAIN_END  = DW'(PIPE_LAT);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_WRITE,
    S_HALT
  } state_t;

  state_t                  state_q,    state_nxt;
  logic [OPCODE_WIDTH-1:0] op_q,       op_nxt;
  logic [ADDR_WIDTH-1:0]   a_base_q,   a_base_nxt;
  logic [ADDR_WIDTH-1:0]   b_base_q,   b_base_nxt;
  logic [ADDR_WIDTH-1:0]   dst_base_q, dst_base_nxt;
  logic [LEN_WIDTH-1:0]    len_q,      len_nxt;
  logic [LEN_WIDTH-1:0]    beat_q,     beat_nxt;
  logic [DW-1:0]           drain_q,    drain_nxt;

  logic [OPCODE_WIDTH-1:0] opcode_nxt;
  logic [ADDR_WIDTH-1:0]   a_addr_nxt, b_addr_nxt, dst_addr_nxt;
  logic                    ready_nxt, busy_nxt, done_nxt, err_nxt, halted_nxt;

  logic                    accept;
  logic [LEN_WIDTH-1:0]    beat_inc;
  logic [ADDR_WIDTH-1:0]   beat_addr;

  // job_ready is only ever high in IDLE, so this also implies state IDLE.
  assign accept    = job_valid & job_ready;
  assign beat_inc  = beat_q + LEN_ONE;
  // Beat offset into address space; the add below wraps modulo 2^ADDR_WIDTH.
  assign beat_addr = ADDR_WIDTH'(beat_q);

  // -------------------------------------------------------------------------
  // Next-state and next-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case statements can leave one unassigned and infer a latch.
    state_nxt    = state_q;
    op_nxt       = op_q;
    a_base_nxt   = a_base_q;
    b_base_nxt   = b_base_q;
    dst_base_nxt = dst_base_q;
    len_nxt      = len_q;
    beat_nxt     = beat_q;
    drain_nxt    = drain_q;
    opcode_nxt   = OP_NOOP;
    a_addr_nxt   = issue_a_addr;
    b_addr_nxt   = issue_b_addr;
    dst_addr_nxt = issue_dst_addr;
    ready_nxt    = 1'b0;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    halted_nxt   = halted;

    case (state_q)
      S_IDLE: begin
        busy_nxt  = 1'b0;
        // Ready drops on the accepting edge and comes back one edge later.
        ready_nxt = ~accept;
        if (accept) begin
          case (job_op)
            OP_ADD, OP_SUB, OP_MUL, OP_DOTP: begin
              if (job_len == '0) begin
                done_nxt = 1'b1;
              end else begin
                op_nxt       = job_op;
                a_base_nxt   = job_a_addr;
                b_base_nxt   = job_b_addr;
                dst_base_nxt = job_dst_addr;
                len_nxt      = job_len;
                beat_nxt     = '0;
                busy_nxt     = 1'b1;
                state_nxt    = S_ISSUE;
              end
            end
            OP_STOP: begin
              opcode_nxt = OP_STOP;
              state_nxt  = S_HALT;
            end
            default: err_nxt = 1'b1;
          endcase
        end
      end

      S_ISSUE: begin
        // A stalled cycle falls through to the NOOP default with the beat
        // counter and addresses held.
        if (!issue_stall) begin
          opcode_nxt   = op_q;
          a_addr_nxt   = a_base_q + beat_addr;
          b_addr_nxt   = b_base_q + beat_addr;
          // Dot products accumulate internally; only STORE_RESULT writes.
          dst_addr_nxt = (op_q == OP_DOTP) ? '0 : dst_base_q + beat_addr;
          beat_nxt     = beat_inc;
          if (beat_inc == len_q) begin
            drain_nxt = '0;
            state_nxt = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        // The pipeline always advances, so issue_stall is not looked at.
        drain_nxt = drain_q + DRAIN_ONE;
        if (op_q == OP_DOTP) begin
          // Leave one edge early so STORE_RESULT lands right after the
          // PIPE_LAT-th bubble.
          if (drain_q == DRAIN_LAST) begin
            state_nxt = S_WRITE;
          end
        end else if (drain_q == DRAIN_END) begin
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end
      end

      S_WRITE: begin
        if (!issue_stall) begin
          opcode_nxt   = OP_STORE;
          dst_addr_nxt = dst_base_q;
          done_nxt     = 1'b1;
          state_nxt    = S_IDLE;
        end
      end

      S_HALT: begin
        busy_nxt   = 1'b0;
        halted_nxt = 1'b1;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  // NOTE: the asynchronous reset clears every register, datapath included,
  // so a reset in the middle of a job blanks the outputs at once and no
  // stale descriptor or counter value survives into the next job.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= S_IDLE;
      op_q           <= OP_NOOP;
      a_base_q       <= '0;
      b_base_q       <= '0;
      dst_base_q     <= '0;
      len_q          <= '0;
      beat_q         <= '0;
      drain_q        <= '0;
      issue_opcode   <= OP_NOOP;
      issue_a_addr   <= '0;
      issue_b_addr   <= '0;
      issue_dst_addr <= '0;
      job_ready      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      halted         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples the
      // pre-edge values computed above regardless of statement order.
      state_q        <= state_nxt;
      op_q           <= op_nxt;
      a_base_q       <= a_base_nxt;
      b_base_q       <= b_base_nxt;
      dst_base_q     <= dst_base_nxt;
      len_q          <= len_nxt;
      beat_q         <= beat_nxt;
      drain_q        <= drain_nxt;
      issue_opcode   <= opcode_nxt;
      issue_a_addr   <= a_addr_nxt;
      issue_b_addr   <= b_addr_nxt;
      issue_dst_addr <= dst_addr_nxt;
      job_ready      <= ready_nxt;
      busy           <= busy_nxt;
      done           <= done_nxt;
      err            <= err_nxt;
      halted         <= halted_nxt;
    end
  end

endmodule
